// File: rtl/quad_pkg.sv
// Shared types and the transition lookup for the quadrature position decoder.
package quad_pkg;

    typedef enum logic [1:0] {
        Q_NONE    = 2'd0,
        Q_UP      = 2'd1,
        Q_DOWN    = 2'd2,
        Q_ILLEGAL = 2'd3
    } q_decode_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Classify a move from the previous {A,B} pair to the current one.
    // Gray order going up is 00 -> 01 -> 11 -> 10 -> 00. A jump of two
    // positions means both channels changed at once and the direction
    // cannot be known.
    function automatic q_decode_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
        q_decode_t r;
        case ({prev, cur})
            4'b0000, 4'b0101, 4'b1111, 4'b1010: r = Q_NONE;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: r = Q_UP;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: r = Q_DOWN;
            default:                            r = Q_ILLEGAL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/quad_sync.sv
// Multi-stage synchronizer for the two asynchronous encoder channels.
module quad_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic qa,
    input  logic qb,
    output logic qa_s,
    output logic qb_s
);

    logic [SYNC_STAGES-1:0] a_q;
    logic [SYNC_STAGES-1:0] b_q;

    // Shift each channel through its flop chain; reset clears the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= {a_q[SYNC_STAGES-2:0], qa};
            b_q <= {b_q[SYNC_STAGES-2:0], qb};
        end
    end

    assign qa_s = a_q[SYNC_STAGES-1];
    assign qb_s = b_q[SYNC_STAGES-1];

endmodule

// File: rtl/quadrature_position_decoder.sv
// Quadrature encoder decoder driving a loadable, wrapping position counter.
module quadrature_position_decoder
    import quad_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             qa,
    input  logic             qb,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic             err_sticky
);

    localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned WW          = $clog2(WARM_CYCLES + 1);
    localparam logic [WW-1:0] WARM_DONE = WW'(WARM_CYCLES);

    logic       qa_s;
    logic       qb_s;
    logic [1:0] s;

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;
    logic [1:0]       prev_q, prev_d;
    logic [WW-1:0]    warm_q, warm_d;
    q_decode_t        dec;

    quad_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .qa   (qa),
        .qb   (qb),
        .qa_s (qa_s),
        .qb_s (qb_s)
    );

    assign s = {qa_s, qb_s};

    // Next-state: warm-up gating, transition decode, counter update, load priority.
    always_comb begin
        count_d  = count_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        err_d    = 1'b0;
        sticky_d = load ? 1'b0 : sticky_q;
        prev_d   = s;
        warm_d   = warm_q;
        dec      = Q_NONE;

        if (warm_q != WARM_DONE) begin
            warm_d = warm_q + 1'b1;
        end else begin
            dec = quad_decode(prev_q, s);
        end

        case (dec)
            Q_UP: begin
                dir_d = DIR_UP;
                if (en) begin
                    step_d  = 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            Q_DOWN: begin
                dir_d = DIR_DOWN;
                if (en) begin
                    step_d  = 1'b1;
                    count_d = count_q - 1'b1;
                end
            end
            // An error coinciding with load still leaves the sticky flag set.
            Q_ILLEGAL: begin
                err_d    = 1'b1;
                sticky_d = 1'b1;
            end
            default: ;
        endcase

        if (load) begin
            count_d = din;
            step_d  = 1'b0;
        end
    end

    // State register with synchronous reset overriding load and decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            dir_q    <= DIR_UP;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            prev_q   <= '0;
            warm_q   <= '0;
        end else begin
            count_q  <= count_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            prev_q   <= prev_d;
            warm_q   <= warm_d;
        end
    end

    assign count      = count_q;
    assign dir        = dir_q;
    assign step       = step_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;

endmodule

// File: doc/quadrature_position_decoder.md
Name: quadrature_position_decoder

Overview:
- Decodes a 2-phase quadrature encoder pair (qa, qb) into up/down steps and drives a loadable, wrapping position counter of the same style as the team's loadable up/down counter.
- It is the producing end of the counter's direction/step interface: it derives `dir` and step enables from the A/B channels instead of taking them from a testbench or controller.
- Sits between board-level encoder inputs (asynchronous) and the position/control logic.

Parameters:
- WIDTH, 4, width of din and count.
- SYNC_STAGES, 2, flip-flop stages on qa/qb for metastability; legal values are ≥2.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- load  input  1  when high, count <= din on the next edge.
- din  input  WIDTH  load value.
- en  input  1  count enable; when low, count holds but A/B state tracking continues.
- qa  input  1  encoder channel A, asynchronous.
- qb  input  1  encoder channel B, asynchronous.
- count  output  WIDTH  current position.
- dir  output  1  last decoded direction: 1 = up, 0 = down.
- step  output  1  one-cycle pulse on each legal decoded transition, gated by en.
- err  output  1  one-cycle pulse on an illegal transition (both channels changed).
- err_sticky  output  1  set by err; cleared only by rst or load.

Behaviour:
- Reset values (on a clk edge with rst=1):
  - count = 0, dir = 1, step = 0, err = 0, err_sticky = 0.
  - Synchronizer regs = 0, prev AB = 00, warm-up counter = 0.
- Synchronizer: qa and qb each pass through SYNC_STAGES flops. The synced pair is s = {qa_s, qb_s}.
- Warm-up: for the first SYNC_STAGES+1 cycles after rst deasserts:
  - prev <= s every cycle.
  - No step or err is produced; count changes only via load.
  - This prevents a false step or error when the encoder rests at a non-00 state.
- Decode (after warm-up), comparing prev to s each cycle, then prev <= s:
  - UP: 00→01, 01→11, 11→10, 10→00.
  - DOWN: 00→10, 10→11, 11→01, 01→00.
  - NONE: s == prev.
  - ILLEGAL: 00↔11 or 01↔10.
- On UP:
  - dir <= 1.
  - If en=1: step <= 1 and count <= count+1, modulo 2^WIDTH (15→0 wraps silently).
- On DOWN:
  - dir <= 0.
  - If en=1: step <= 1 and count <= count-1, modulo 2^WIDTH (0→15 wraps).
- On ILLEGAL:
  - err <= 1 and err_sticky <= 1.
  - count and dir unchanged; step = 0.
- On NONE: count, dir, err_sticky unchanged; step = 0; err = 0.
- step and err are registered one-cycle pulses and are never high in the same cycle.
- Latency: an edge on qa/qb is reflected in count/step/dir after exactly SYNC_STAGES+1 rising edges (3 cycles at default).
- en=0: no count change and no step pulse. dir still updates. err still fires.
- Load priority: load > decode.
  - With load=1, count <= din regardless of en or any simultaneous transition; a coincident step is dropped (step = 0).
  - prev still updates, and dir updates per the decode.
  - load clears err_sticky. If an ILLEGAL transition coincides with load, err pulses and err_sticky ends set (set wins over clear).
- Reset mid-operation: rst overrides load and decode on the same edge and restarts warm-up.
- Input rate: the encoder must not change state more than once per SYNC_STAGES+1 cycles. Faster inputs appear as ILLEGAL and are reported, not corrected.

Decomposition:
- Shared package quad_pkg holds:
  - Decode type enumeration: Q_NONE, Q_UP, Q_DOWN, Q_ILLEGAL (2 bits).
  - DIR_UP = 1, DIR_DOWN = 0.
  - A constant function or lookup that maps {prev, s} (4 bits) to a decode type.
- One sub-module, quad_sync:
  - Parameterised SYNC_STAGES synchronizer for both channels.
  - Synchronous active-high reset to 0.
  - Outputs qa_s and qb_s.
- The top block holds warm-up, decode, counter, and flags.

Test Plan:
- Reset with qa=qb=1 held, then release rst and wait 5 cycles → count=0, dir=1, step never pulses, err never pulses.
- Load din=4 (one-cycle load), then drive forward sequence 00→01→11→10→00 with 4 cycles per state, en=1 → four step pulses; count 4→8; dir=1; each update lands 3 cycles after the input change.
- From count=1, drive reverse 00→10→11→01 → count 1→0→15→14 (wrap); dir=0; three step pulses.
- Drive 00→11 directly → err pulses once, err_sticky=1, count unchanged. Then pulse load with din=9 → count=9, err_sticky=0.
- en=0 with 4 forward transitions → count unchanged, step=0, dir=1. Then en=1 plus one reverse transition → count-1, dir=0.
- Load asserted in the same cycle a decoded UP lands (din=2, count=7) → count=2, step=0, dir=1. Assert rst mid-sequence → all outputs return to reset values on the next edge.
